simplebus_arbiter: RTL and testbench



---
 rtl/simplebus_pkg.sv | 29 ++
 rtl/simplebus_arbiter_rr_pick.sv | 36 +++
 rtl/simplebus_arbiter.sv | 146 ++++++++++++++
 tb/tb_simplebus_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebus_pkg.sv
// Shared SimpleBus definitions: command codes, field widths and the arbiter state encoding.
package simplebus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int USER_W = 16;
    localparam int SIZE_W = 3;
    localparam int CMD_W  = 4;

    typedef enum logic [3:0] {
        CMD_READ        = 4'b0000,
        CMD_WRITE       = 4'b0001,
        CMD_READ_BURST  = 4'b0010,
        CMD_WRITE_BURST = 4'b0011,
        CMD_PREFETCH    = 4'b0100,
        CMD_WRITE_LAST  = 4'b0111
    } sb_cmd_e;

    localparam logic [3:0] RESP_READ_LAST  = 4'b0110;
    localparam logic [3:0] RESP_WRITE_RESP = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/simplebus_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid bit at or above ptr, wrapping around.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_valid
);

    logic [2*N-1:0] rot_s;
    logic [W:0]     sum_s;

    // Rotate so bit k is master (ptr+k) mod N; scan downward so the smallest offset wins.
    always_comb begin
        rot_s     = {valid, valid} >> ptr;
        sum_s     = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                sum_s     = {1'b0, ptr} + (W+1)'(k);
                any_valid = 1'b1;
                if (sum_s >= (W+1)'(N)) begin
                    winner = W'(sum_s - (W+1)'(N));
                end else begin
                    winner = sum_s[W-1:0];
                end
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/simplebus_arbiter.sv
// Round-robin arbiter sharing one SimpleBus slave between NUM_REQ masters, one transaction at a time.
module simplebus_arbiter
    import simplebus_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      m_req_valid,
    output logic [NUM_REQ-1:0]      m_req_ready,
    input  logic [NUM_REQ*32-1:0]   m_req_addr,
    input  logic [NUM_REQ*3-1:0]    m_req_size,
    input  logic [NUM_REQ*4-1:0]    m_req_cmd,
    input  logic [NUM_REQ*8-1:0]    m_req_wmask,
    input  logic [NUM_REQ*64-1:0]   m_req_wdata,
    input  logic [NUM_REQ*16-1:0]   m_req_user,
    output logic [NUM_REQ-1:0]      m_resp_valid,
    input  logic [NUM_REQ-1:0]      m_resp_ready,
    output logic [3:0]              m_resp_cmd,
    output logic [63:0]             m_resp_rdata,
    output logic [15:0]             m_resp_user,
    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    output logic [31:0]             s_req_addr,
    output logic [2:0]              s_req_size,
    output logic [3:0]              s_req_cmd,
    output logic [7:0]              s_req_wmask,
    output logic [63:0]             s_req_wdata,
    output logic [15:0]             s_req_user,
    input  logic                    s_resp_valid,
    output logic                    s_resp_ready,
    input  logic [3:0]              s_resp_cmd,
    input  logic [63:0]             s_resp_rdata,
    input  logic [15:0]             s_resp_user,
    output logic                    busy,
    output logic [GNT_W-1:0]        gnt_idx
);

    arb_state_e       state_r, state_next_s;
    logic [GNT_W-1:0] gnt_idx_r, gnt_next_s;
    logic [GNT_W-1:0] rr_ptr_r, rr_ptr_next_s;
    logic [GNT_W-1:0] winner_s;
    logic             any_valid_s;
    logic             is_rburst_r, is_rburst_next_s;

    rr_pick #(.N(NUM_REQ), .W(GNT_W)) u_pick (
        .valid     (m_req_valid),
        .ptr       (rr_ptr_r),
        .winner    (winner_s),
        .any_valid (any_valid_s)
    );

    // State, grant, pointer and burst-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            gnt_idx_r   <= '0;
            rr_ptr_r    <= '0;
            is_rburst_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            gnt_idx_r   <= gnt_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
            is_rburst_r <= is_rburst_next_s;
        end
    end

    // Next-state logic and handshake routing; everything is zero outside the owning state.
    always_comb begin
        state_next_s     = state_r;
        gnt_next_s       = gnt_idx_r;
        rr_ptr_next_s    = rr_ptr_r;
        is_rburst_next_s = is_rburst_r;
        m_req_ready      = '0;
        m_resp_valid     = '0;
        m_resp_cmd       = 4'b0000;
        m_resp_rdata     = 64'h0;
        m_resp_user      = 16'h0;
        s_req_valid      = 1'b0;
        s_req_addr       = 32'h0;
        s_req_size       = 3'b000;
        s_req_cmd        = 4'b0000;
        s_req_wmask      = 8'h00;
        s_req_wdata      = 64'h0;
        s_req_user       = 16'h0;
        s_resp_ready     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    gnt_next_s    = winner_s;
                    rr_ptr_next_s = (winner_s == GNT_W'(NUM_REQ - 1)) ? '0 : winner_s + GNT_W'(1);
                    state_next_s  = ST_REQ;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                s_req_valid              = m_req_valid[gnt_idx_r];
                s_req_addr               = m_req_addr[gnt_idx_r*ADDR_W +: ADDR_W];
                s_req_size               = m_req_size[gnt_idx_r*SIZE_W +: SIZE_W];
                s_req_cmd                = m_req_cmd[gnt_idx_r*CMD_W +: CMD_W];
                s_req_wmask              = m_req_wmask[gnt_idx_r*MASK_W +: MASK_W];
                s_req_wdata              = m_req_wdata[gnt_idx_r*DATA_W +: DATA_W];
                s_req_user               = m_req_user[gnt_idx_r*USER_W +: USER_W];
                m_req_ready[gnt_idx_r]   = s_req_ready;
                if (s_req_valid && s_req_ready) begin
                    is_rburst_next_s = (s_req_cmd == CMD_READ_BURST);
                    if (s_req_cmd == CMD_WRITE_BURST) begin
                        state_next_s = ST_REQ;
                    end else if (s_req_cmd == CMD_PREFETCH) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RESP: begin
                m_resp_valid[gnt_idx_r] = s_resp_valid;
                s_resp_ready            = m_resp_ready[gnt_idx_r];
                m_resp_cmd              = s_resp_cmd;
                m_resp_rdata            = s_resp_rdata;
                m_resp_user             = s_resp_user;
                if (s_resp_valid && s_resp_ready) begin
                    // Read bursts hold the grant until the slave marks the last beat.
                    if (is_rburst_r && (s_resp_cmd != RESP_READ_LAST)) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_r != ST_IDLE);
    assign gnt_idx = gnt_idx_r;

endmodule

// File: tb/tb_simplebus_arbiter.sv
// Self-checking bench for simplebus_arbiter: directed scenarios plus randomized rounds against a rotation model.
module tb_simplebus_arbiter;

    localparam int N  = 2;
    localparam int GW = 1;
    localparam logic [3:0] C_READ = 4'b0000, C_WRITE = 4'b0001, C_RBURST = 4'b0010;
    localparam logic [3:0] C_WBURST = 4'b0011, C_PREF = 4'b0100, C_WLAST = 4'b0111;
    localparam logic [3:0] R_RLAST = 4'b0110, R_WRESP = 4'b0101;

    logic            clk, rst;
    logic [N-1:0]    m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
    logic [N*32-1:0] m_req_addr;
    logic [N*3-1:0]  m_req_size;
    logic [N*4-1:0]  m_req_cmd;
    logic [N*8-1:0]  m_req_wmask;
    logic [N*64-1:0] m_req_wdata;
    logic [N*16-1:0] m_req_user;
    logic [3:0]      m_resp_cmd, s_req_cmd, s_resp_cmd;
    logic [63:0]     m_resp_rdata, s_req_wdata, s_resp_rdata;
    logic [15:0]     m_resp_user, s_req_user, s_resp_user;
    logic            s_req_valid, s_req_ready, s_resp_valid, s_resp_ready, busy;
    logic [31:0]     s_req_addr;
    logic [2:0]      s_req_size;
    logic [7:0]      s_req_wmask;
    logic [GW-1:0]   gnt_idx;

    int total = 0;
    int bad = 0;
    int model_ptr = 0;

    simplebus_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_size(m_req_size), .m_req_cmd(m_req_cmd), .m_req_wmask(m_req_wmask),
        .m_req_wdata(m_req_wdata), .m_req_user(m_req_user),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_cmd(m_resp_cmd),
        .m_resp_rdata(m_resp_rdata), .m_resp_user(m_resp_user),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_size(s_req_size), .s_req_cmd(s_req_cmd), .s_req_wmask(s_req_wmask),
        .s_req_wdata(s_req_wdata), .s_req_user(s_req_user),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_cmd(s_resp_cmd),
        .s_resp_rdata(s_resp_rdata), .s_resp_user(s_resp_user),
        .busy(busy), .gnt_idx(gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        oh = N'(1) << i;
    endfunction

    function automatic logic [3:0] rand_cmd();
        case ($urandom_range(0, 2))
            0:       rand_cmd = C_READ;
            1:       rand_cmd = C_WRITE;
            default: rand_cmd = C_PREF;
        endcase
    endfunction

    task automatic set_master(input int i, input logic [3:0] cmd, input logic [31:0] addr);
        m_req_valid[i]          = 1'b1;
        m_req_cmd[i*4 +: 4]     = cmd;
        m_req_addr[i*32 +: 32]  = addr;
        m_req_size[i*3 +: 3]    = 3'($urandom());
        m_req_wmask[i*8 +: 8]   = 8'($urandom());
        m_req_wdata[i*64 +: 64] = {$urandom(), $urandom()};
        m_req_user[i*16 +: 16]  = 16'($urandom());
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_req_valid = '0; m_req_addr = '0; m_req_size = '0; m_req_cmd = '0;
        m_req_wmask = '0; m_req_wdata = '0; m_req_user = '0; m_resp_ready = '0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_cmd = 4'b0000;
        s_resp_rdata = 64'h0; s_resp_user = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({s_req_valid, m_req_ready, m_resp_valid, s_resp_ready, busy} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0", {s_req_valid, m_req_ready, m_resp_valid, s_resp_ready, busy});
        end
        total++;
        if (gnt_idx !== 1'b0 || s_req_addr !== 32'h0 || s_req_wdata !== 64'h0) begin
            bad++;
            $display("FAIL reset_fields gnt=%0d addr=%h wdata=%h want 0", gnt_idx, s_req_addr, s_req_wdata);
        end
        rst = 1'b1;
        step();
        model_ptr = 0;
    endtask

    task automatic test_single_read();
        logic [63:0] rd = 64'hDEAD_BEEF_0000_0001;
        set_master(1, C_READ, 32'h8000_0100);
        s_req_ready = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || s_req_valid !== 1'b0) begin
            bad++; $display("FAIL sr_arb_cycle busy=%b s_req_valid=%b want 0,0", busy, s_req_valid);
        end
        step();
        @(negedge clk);
        total++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0100) begin
            bad++; $display("FAIL sr_fwd valid=%b addr=%h want 1,80000100", s_req_valid, s_req_addr);
        end
        total++;
        if (gnt_idx !== 1'b1 || m_req_ready !== 2'b10) begin
            bad++; $display("FAIL sr_gnt gnt=%0d ready=%b want 1,10", gnt_idx, m_req_ready);
        end
        step();
        m_req_valid[1] = 1'b0; s_req_ready = 1'b0;
        s_resp_valid = 1'b1; s_resp_cmd = R_RLAST; s_resp_rdata = rd; m_resp_ready = 2'b10;
        @(negedge clk);
        total++;
        if (m_resp_valid !== 2'b10 || m_resp_rdata !== rd || s_resp_ready !== 1'b1) begin
            bad++; $display("FAIL sr_resp valid=%b rdata=%h sready=%b want 10,%h,1", m_resp_valid, m_resp_rdata, s_resp_ready, rd);
        end
        step();
        s_resp_valid = 1'b0; m_resp_ready = '0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL sr_busy_drop busy=%b want 0", busy);
        end
        step();
        model_ptr = 0;
    endtask

    // Generic single-beat round: masters in 'set' all request at once; service order follows the rotation.
    task automatic run_txns(input logic [N-1:0] set, input logic [N*4-1:0] cmds, input string tag);
        int          order[$];
        int          head, cycles;
        bit          req_hs, resp_hs, resp_pend, resp_live, bubble;
        logic [31:0] exp_addr [N];
        logic [63:0] exp_rdata;
        for (int k = 0; k < N; k++) begin
            int m;
            m = (model_ptr + k) % N;
            if (set[m]) order.push_back(m);
        end
        for (int i = 0; i < N; i++) begin
            exp_addr[i] = 32'h0;
            if (set[i]) begin
                exp_addr[i] = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
                set_master(i, cmds[i*4 +: 4], exp_addr[i]);
            end
        end
        head = 0; cycles = 0; exp_rdata = 64'h0;
        req_hs = 0; resp_hs = 0; resp_pend = 0; resp_live = 0; bubble = 0;
        while ((order.size() != 0 || bubble) && cycles < 400) begin
            cycles++;
            if (order.size() != 0) head = order[0];
            s_req_ready  = 1'($urandom_range(0, 1));
            m_resp_ready = N'($urandom());
            if (!resp_pend) begin
                s_resp_valid = ($urandom_range(0, 3) == 0);
            end else if (!resp_live) begin
                s_resp_valid = 1'($urandom_range(0, 1));
                if (s_resp_valid) begin
                    resp_live    = 1;
                    exp_rdata    = {$urandom(), $urandom()};
                    s_resp_rdata = exp_rdata;
                    s_resp_user  = 16'($urandom());
                    s_resp_cmd   = (m_req_cmd[head*4 +: 4] == C_WRITE) ? R_WRESP : R_RLAST;
                end
            end
            @(negedge clk);
            req_hs = 0; resp_hs = 0;
            if (bubble) begin
                total++;
                if (busy !== 1'b0 || s_req_valid !== 1'b0) begin
                    bad++; $display("FAIL %s_bubble busy=%b s_req_valid=%b want 0,0", tag, busy, s_req_valid);
                end
                bubble = 0;
            end
            if (s_req_valid === 1'b1) begin
                total++;
                if (resp_pend || s_req_addr !== exp_addr[head] || gnt_idx !== GW'(head)) begin
                    bad++; $display("FAIL %s_req_src addr=%h gnt=%0d want addr=%h gnt=%0d", tag, s_req_addr, gnt_idx, exp_addr[head], head);
                end
                total++;
                if (m_req_ready !== (s_req_ready ? oh(head) : '0)) begin
                    bad++; $display("FAIL %s_req_ready got=%b want=%b", tag, m_req_ready, s_req_ready ? oh(head) : '0);
                end
                if (s_req_ready) req_hs = 1;
            end
            if (resp_pend) begin
                total++;
                if (m_resp_valid !== (s_resp_valid ? oh(head) : '0) || s_resp_ready !== m_resp_ready[head]) begin
                    bad++; $display("FAIL %s_resp_route valid=%b sready=%b want valid=%b sready=%b", tag, m_resp_valid, s_resp_ready, s_resp_valid ? oh(head) : '0, m_resp_ready[head]);
                end
                if (s_resp_valid && m_resp_ready[head]) begin
                    total++;
                    if (m_resp_rdata !== exp_rdata) begin
                        bad++; $display("FAIL %s_rdata got=%h want=%h", tag, m_resp_rdata, exp_rdata);
                    end
                    resp_hs = 1;
                end
            end else begin
                total++;
                if (s_resp_ready !== 1'b0 || m_resp_valid !== '0) begin
                    bad++; $display("FAIL %s_resp_leak sready=%b valid=%b want 0", tag, s_resp_ready, m_resp_valid);
                end
            end
            step();
            if (req_hs) begin
                m_req_valid[head] = 1'b0;
                model_ptr = (head + 1) % N;
                if (m_req_cmd[head*4 +: 4] == C_PREF) begin
                    void'(order.pop_front());
                    bubble = 1;
                end else begin
                    resp_pend = 1; resp_live = 0; s_resp_valid = 1'b0;
                end
            end
            if (resp_hs) begin
                s_resp_valid = 1'b0; resp_pend = 0; resp_live = 0;
                void'(order.pop_front());
                bubble = 1;
            end
        end
        total++;
        if (order.size() != 0) begin
            bad++; $display("FAIL %s_timeout pending=%0d want 0", tag, order.size());
        end
        s_req_ready = 1'b0; s_resp_valid = 1'b0; m_resp_ready = '0;
    endtask

    task automatic test_write_burst();
        logic [31:0] ba [3] = '{32'h1000_0000, 32'h1000_0008, 32'h1000_0010};
        logic [3:0]  bc [3] = '{C_WBURST, C_WBURST, C_WLAST};
        set_master(0, bc[0], ba[0]);
        s_req_ready = 1'b1;
        step();
        set_master(1, C_READ, 32'h2000_0040);
        for (int b = 0; b < 3; b++) begin
            m_req_cmd[3:0] = bc[b]; m_req_addr[31:0] = ba[b];
            @(negedge clk);
            total++;
            if (s_req_valid !== 1'b1 || s_req_addr !== ba[b] || s_req_cmd !== bc[b] || m_req_ready !== 2'b01 || gnt_idx !== 1'b0) begin
                bad++; $display("FAIL wb_beat%0d valid=%b addr=%h cmd=%b ready=%b gnt=%0d want 1,%h,%b,01,0", b, s_req_valid, s_req_addr, s_req_cmd, m_req_ready, gnt_idx, ba[b], bc[b]);
            end
            step();
        end
        m_req_valid[0] = 1'b0; s_req_ready = 1'b0;
        s_resp_valid = 1'b1; s_resp_cmd = R_WRESP; m_resp_ready = 2'b11;
        @(negedge clk);
        total++;
        if (m_resp_valid !== 2'b01 || s_req_valid !== 1'b0 || m_req_ready !== 2'b00) begin
            bad++; $display("FAIL wb_resp valid=%b s_req_valid=%b ready=%b want 01,0,00", m_resp_valid, s_req_valid, m_req_ready);
        end
        step();
        s_resp_valid = 1'b0; m_resp_ready = '0; s_req_ready = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL wb_bubble busy=%b want 0", busy);
        end
        step();
        @(negedge clk);
        total++;
        if (gnt_idx !== 1'b1 || s_req_addr !== 32'h2000_0040 || m_req_ready !== 2'b10) begin
            bad++; $display("FAIL wb_next gnt=%0d addr=%h ready=%b want 1,20000040,10", gnt_idx, s_req_addr, m_req_ready);
        end
        step();
        m_req_valid[1] = 1'b0; s_req_ready = 1'b0;
        s_resp_valid = 1'b1; s_resp_cmd = R_RLAST; m_resp_ready = 2'b10;
        @(negedge clk);
        total++;
        if (m_resp_valid !== 2'b10) begin
            bad++; $display("FAIL wb_next_resp valid=%b want 10", m_resp_valid);
        end
        step();
        s_resp_valid = 1'b0; m_resp_ready = '0;
        step();
        model_ptr = 0;
    endtask

    task automatic test_read_burst();
        logic [63:0] rd;
        set_master(1, C_RBURST, 32'h8000_0200);
        s_req_ready = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (s_req_valid !== 1'b1 || m_req_ready !== 2'b10 || s_req_cmd !== C_RBURST) begin
            bad++; $display("FAIL rb_req valid=%b ready=%b cmd=%b want 1,10,0010", s_req_valid, m_req_ready, s_req_cmd);
        end
        step();
        m_req_valid[1] = 1'b0; s_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rd = {$urandom(), $urandom()};
            s_resp_valid = 1'b1; s_resp_cmd = (b == 3) ? R_RLAST : C_READ; s_resp_rdata = rd;
            if (b == 1) begin
                m_resp_ready = 2'b00;
                @(negedge clk);
                total++;
                if (m_resp_valid !== 2'b10 || s_resp_ready !== 1'b0) begin
                    bad++; $display("FAIL rb_stall valid=%b sready=%b want 10,0", m_resp_valid, s_resp_ready);
                end
                step();
            end
            m_resp_ready = 2'b10;
            @(negedge clk);
            total++;
            if (m_resp_valid !== 2'b10 || s_resp_ready !== 1'b1 || m_resp_rdata !== rd) begin
                bad++; $display("FAIL rb_beat%0d valid=%b sready=%b rdata=%h want 10,1,%h", b, m_resp_valid, s_resp_ready, m_resp_rdata, rd);
            end
            step();
        end
        s_resp_valid = 1'b0; m_resp_ready = '0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rb_done busy=%b want 0", busy);
        end
        step();
        model_ptr = 0;
    endtask

    task automatic test_reset_mid();
        set_master(1, C_READ, 32'h4000_0000);
        s_req_ready = 1'b1;
        step();
        step();
        m_req_valid[1] = 1'b0; s_req_ready = 1'b0;
        s_resp_valid = 1'b1; s_resp_cmd = R_RLAST; m_resp_ready = 2'b11;
        #1;
        total++;
        if (m_resp_valid !== 2'b10 || gnt_idx !== 1'b1) begin
            bad++; $display("FAIL rm_setup valid=%b gnt=%0d want 10,1", m_resp_valid, gnt_idx);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({s_req_valid, m_req_ready, m_resp_valid, s_resp_ready, busy} !== '0 || gnt_idx !== 1'b0) begin
            bad++; $display("FAIL rm_async ctrl=%b gnt=%0d want 0,0", {s_req_valid, m_req_ready, m_resp_valid, s_resp_ready, busy}, gnt_idx);
        end
        s_resp_valid = 1'b0; m_resp_ready = '0;
        step();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt_idx !== 1'b0) begin
            bad++; $display("FAIL rm_release busy=%b gnt=%0d want 0,0", busy, gnt_idx);
        end
        step();
        model_ptr = 0;
    endtask

    task automatic test_random();
        logic [N-1:0]   set;
        logic [N*4-1:0] cmds;
        for (int r = 0; r < 40; r++) begin
            set = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) cmds[i*4 +: 4] = rand_cmd();
            run_txns(set, cmds, "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        run_txns(2'b11, {C_READ, C_READ}, "both");
        run_txns(2'b11, {C_READ, C_READ}, "both_again");
        test_write_burst();
        test_read_burst();
        run_txns(2'b01, {C_READ, C_PREF}, "pref");
        test_random();
        test_reset_mid();
        run_txns(2'b11, {C_WRITE, C_READ}, "post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
